imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
Shares the single-port combinational instruction ROM (9-bit word address, 32-bit data) between two requesters.
- The pipeline IF stage fetches one word per cycle and has priority.
- A debug burst reader dumps consecutive ROM words for trace and verification.
- A starvation counter guarantees the debug port forward progress.
- Read data is registered, so both ports see a fixed 1-cycle latency.

Parameters:
ADDR_W, 9, ROM word-address width
DATA_W, 32, instruction width
STARVE_MAX, 4, consecutive denied debug cycles before debug is forced a slot (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  IF stage requests a fetch this cycle
if_addr  in  ADDR_W  IF word address
if_stall  out  1  combinational; if_req high but slot given to debug
if_valid  out  1  registered; if_data valid
if_data  out  DATA_W  registered fetched instruction
dbg_start  in  1  one-cycle pulse: begin burst
dbg_base  in  ADDR_W  burst start address, sampled on accepted dbg_start
dbg_len  in  8  burst length minus 1 (0 = 1 word, 255 = 256 words)
dbg_busy  out  1  registered; burst in progress
dbg_valid  out  1  registered; dbg_data valid
dbg_data  out  DATA_W  registered burst word
dbg_idx  out  8  registered; index of dbg_data within burst
dbg_done  out  1  registered; pulses with the last dbg_valid
rom_addr  out  ADDR_W  combinational address to ROM
rom_data  in  DATA_W  combinational ROM output

Behaviour:
- Reset (rst_n low at clk edge):
  - All registered outputs go to 0; state to IDLE; starve counter to 0; burst counters to 0.
  - Reset mid-burst aborts it with no dbg_done.
- States: IDLE, BURST.
  - IDLE -> BURST on dbg_start; the block latches cur_addr=dbg_base, remaining=dbg_len, idx=0, and sets dbg_busy=1 next cycle.
  - dbg_start while BURST is ignored.
- Slot decision, per cycle, combinational. dbg_want = (state==BURST).
  - Grant IF if if_req and not (dbg_want and starve==STARVE_MAX).
  - Else grant debug if dbg_want.
  - Else no grant.
- rom_addr: if_addr when IF is granted, cur_addr when debug is granted, otherwise if_addr (don't-care, held for low toggling).
- if_stall = if_req and debug granted.
- Latency: a granted access in cycle N produces rom_data registered into if_data or dbg_data, with the matching valid set, in cycle N+1. Valids are single-cycle unless the port is granted again in N+1.
  - if_data holds its last value when if_valid=0.
- Starve counter:
  - Increments when dbg_want and debug is not granted (saturates at STARVE_MAX).
  - Clears on a debug grant or in IDLE.
- Debug grant:
  - cur_addr increments modulo 2^ADDR_W (511 wraps to 0); idx increments.
  - If remaining==0 this is the last word: state -> IDLE, dbg_busy=0 and dbg_done=1 registered together with that word's dbg_valid.
  - Otherwise remaining decrements.
- dbg_start in the same cycle as the burst's final grant is ignored (state is still BURST).
- dbg_start accepted in IDLE is not eligible for a grant until the next cycle.
- At most one ROM access per cycle; IF and debug are never granted together.

Test Plan:
Bench ROM model holds the program image: word0=00000000, word1=8d100000, word2=00102021, word4=0c100010, word511=00000000.
- IF-only: if_req=1, if_addr=1 then 2 -> if_valid=1 with if_data=8d100000 then 00102021, one cycle after each; if_stall=0 throughout; dbg outputs stay 0.
- Burst, idle IF: dbg_start, base=0, len=4 -> 5 consecutive dbg_valid, idx 0..4, data 00000000,8d100000,00102021,21050004,0c100010; dbg_done with idx=4; dbg_busy falls the same cycle.
- Starvation, STARVE_MAX=4: if_req held 1, burst base=1, len=1 -> debug granted on the 5th BURST cycle with if_stall=1 that cycle; data 8d100000 next cycle; second word after another 4 denied cycles; done with 00102021.
- Wrap: base=510, len=2 -> dbg_data words 510, 511, 0 (idx 0,1,2), rom_addr sequence 1FE,1FF,000.
- Ignored start: dbg_start pulsed mid-burst with base=100 -> burst data unchanged, exactly len+1 words, one dbg_done.
- Reset mid-burst: rst_n low for one edge during base=0, len=9 -> all outputs 0 next cycle, no dbg_done, state IDLE; a new dbg_start runs normally.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares one combinational instruction ROM between the
// pipeline IF stage (priority) and a debug burst reader. A starvation counter
// forces a debug slot after STARVE_MAX consecutive denials. Read data is
// registered, so both ports see a fixed one-cycle latency.
module imem_fetch_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    input  logic              dbg_start,
    input  logic [ADDR_W-1:0] dbg_base,
    input  logic [7:0]        dbg_len,
    output logic              dbg_busy,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic [7:0]        dbg_idx,
    output logic              dbg_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [7:0]          remaining_q, remaining_d;
    logic [7:0]          idx_q, idx_d;
    logic [3:0]          starve_q, starve_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic                dbg_valid_q, dbg_valid_d;
    logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
    logic [7:0]          dbg_idx_q, dbg_idx_d;
    logic                dbg_done_q, dbg_done_d;

    logic dbg_want;
    logic if_grant;
    logic dbg_grant;

    // Slot decision: IF wins unless debug has waited STARVE_MAX cycles.
    always_comb begin
        dbg_want  = (state_q == BURST);
        if_grant  = if_req && !(dbg_want && (starve_q == STARVE_LIM));
        dbg_grant = dbg_want && !if_grant;
        // Non-granted cycles keep if_addr on the bus to limit toggling.
        rom_addr  = dbg_grant ? cur_addr_q : if_addr;
        if_stall  = if_req && dbg_grant;
    end

    // Next-state for the burst FSM, starvation counter and read-data registers.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        starve_d    = 4'd0;
        if_valid_d  = if_grant;
        if_data_d   = if_grant ? rom_data : if_data_q;
        dbg_valid_d = dbg_grant;
        dbg_data_d  = dbg_grant ? rom_data : dbg_data_q;
        dbg_idx_d   = dbg_grant ? idx_q : dbg_idx_q;
        dbg_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start accepted here is only eligible for a slot next cycle.
                if (dbg_start) begin
                    state_d     = BURST;
                    cur_addr_d  = dbg_base;
                    remaining_d = dbg_len;
                    idx_d       = 8'd0;
                end
            end
            BURST: begin
                // dbg_start is ignored for the whole burst, including its last grant.
                if (dbg_grant) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    idx_d      = idx_q + 8'd1;
                    if (remaining_q == 8'd0) begin
                        state_d    = IDLE;
                        dbg_done_d = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                    end
                end else begin
                    starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            starve_q    <= '0;
            if_valid_q  <= 1'b0;
            if_data_q   <= '0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
            dbg_idx_q   <= '0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            starve_q    <= starve_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
            dbg_idx_q   <= dbg_idx_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign dbg_busy  = (state_q == BURST);
    assign if_valid  = if_valid_q;
    assign if_data   = if_data_q;
    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_idx   = dbg_idx_q;
    assign dbg_done  = dbg_done_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Testbench for imem_fetch_arbiter: directed scenarios with literal
// expectations, plus a queue-based reference model compared every cycle.
module tb_imem_fetch_arbiter;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_stall;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;
    logic              dbg_start;
    logic [ADDR_W-1:0] dbg_base;
    logic [7:0]        dbg_len;
    logic              dbg_busy;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_data;
    logic [7:0]        dbg_idx;
    logic              dbg_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    logic [DATA_W-1:0] rom [512];

    always #5 clk = ~clk;

    imem_fetch_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
        .if_valid(if_valid), .if_data(if_data),
        .dbg_start(dbg_start), .dbg_base(dbg_base), .dbg_len(dbg_len),
        .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_data(dbg_data),
        .dbg_idx(dbg_idx), .dbg_done(dbg_done),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    assign rom_data = rom[rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending burst addresses kept as a queue.
    int          mq[$];
    int          sent;
    int          starve;
    bit          m_ready = 1'b0;
    logic        m_if_valid, m_dbg_valid, m_dbg_done;
    logic [31:0] m_if_data, m_dbg_data;
    logic [7:0]  m_dbg_idx;

    function automatic void decide(output bit ig, output bit dg);
        bit want;
        want = (mq.size() != 0);
        ig   = if_req && !(want && starve == STARVE_MAX);
        dg   = want && !ig;
    endfunction

    always @(posedge clk) begin
        bit ig, dg, want;
        want = (mq.size() != 0);
        decide(ig, dg);
        if (!rst_n) begin
            mq.delete();
            sent = 0; starve = 0;
            m_if_valid = 0; m_if_data = 0;
            m_dbg_valid = 0; m_dbg_data = 0; m_dbg_idx = 0; m_dbg_done = 0;
        end else begin
            m_if_valid = ig;
            if (ig) m_if_data = rom[if_addr];
            m_dbg_valid = dg;
            m_dbg_done  = 0;
            if (dg) begin
                m_dbg_data = rom[mq[0]];
                m_dbg_idx  = 8'(sent);
                sent++;
                void'(mq.pop_front());
                if (mq.size() == 0) m_dbg_done = 1;
                starve = 0;
            end else if (want) begin
                if (starve < STARVE_MAX) starve++;
            end else begin
                starve = 0;
            end
            if (!want && dbg_start) begin
                for (int k = 0; k <= int'(dbg_len); k++) mq.push_back((int'(dbg_base) + k) % 512);
                sent = 0;
            end
        end
        m_ready = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit ig, dg;
        if (m_ready) begin
            decide(ig, dg);
            check("rom_addr",  32'(rom_addr),  dg ? 32'(mq[0]) : 32'(if_addr));
            check("if_stall",  32'(if_stall),  32'(if_req && dg));
            check("if_valid",  32'(if_valid),  32'(m_if_valid));
            check("if_data",   if_data,        m_if_data);
            check("dbg_valid", 32'(dbg_valid), 32'(m_dbg_valid));
            check("dbg_data",  dbg_data,       m_dbg_data);
            check("dbg_idx",   32'(dbg_idx),   32'(m_dbg_idx));
            check("dbg_done",  32'(dbg_done),  32'(m_dbg_done));
            check("dbg_busy",  32'(dbg_busy),  32'(mq.size() != 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got_data[$];
    int          got_idx[$];
    int          got_addr[$];
    int          got_cyc[$];
    int          done_cnt;
    int          done_idx;
    logic        busy_at_done;
    int          n_stall;

    task automatic start_burst(input int base, input int len);
        dbg_start = 1'b1;
        dbg_base  = ADDR_W'(base);
        dbg_len   = 8'(len);
        step();
        dbg_start = 1'b0;
    endtask

    // Steps until dbg_busy falls (bounded), recording what the debug port shows.
    task automatic collect(input int budget, input int pulse_at);
        got_data.delete(); got_idx.delete(); got_addr.delete(); got_cyc.delete();
        done_cnt = 0; done_idx = -1; busy_at_done = 1'b1; n_stall = 0;
        for (int k = 1; k <= budget; k++) begin
            if (dbg_busy && !if_req) got_addr.push_back(int'(rom_addr));
            if (if_stall) n_stall++;
            dbg_start = (k == pulse_at);
            if (k == pulse_at) begin
                dbg_base = ADDR_W'(100);
                dbg_len  = 8'd0;
            end
            step();
            dbg_start = 1'b0;
            if (dbg_valid) begin
                got_data.push_back(dbg_data);
                got_idx.push_back(int'(dbg_idx));
                got_cyc.push_back(k);
            end
            if (dbg_done) begin
                done_cnt++;
                done_idx     = int'(dbg_idx);
                busy_at_done = dbg_busy;
            end
            if (!dbg_busy) break;
        end
        check("burst_ends_in_budget", 32'(dbg_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_b[5];
        exp_b = '{32'h00000000, 32'h8d100000, 32'h00102021, 32'h21050004, 32'h0c100010};

        for (int k = 0; k < 512; k++) rom[k] = 32'h5a000000 ^ (32'(k) * 32'h00010001);
        rom[0] = 32'h00000000; rom[1] = 32'h8d100000; rom[2] = 32'h00102021;
        rom[3] = 32'h21050004; rom[4] = 32'h0c100010; rom[511] = 32'h00000000;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dbg_start = 1'b0; dbg_base = '0; dbg_len = '0;
        step(); step();
        rst_n = 1'b1;
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_dbg_busy", 32'(dbg_busy), 32'd0);
        check("reset_if_data",  if_data,       32'd0);
        step();

        // IF-only fetches.
        if_req = 1'b1; if_addr = 9'd1;
        check("if_only_stall", 32'(if_stall), 32'd0);
        step();
        check("if_only_valid1", 32'(if_valid), 32'd1);
        check("if_only_data1",  if_data,       32'h8d100000);
        if_addr = 9'd2;
        step();
        check("if_only_data2",  if_data,       32'h00102021);
        check("if_only_dbgv",   32'(dbg_valid), 32'd0);
        if_req = 1'b0;
        step();
        check("if_data_holds",  if_data,       32'h00102021);
        check("if_valid_drops", 32'(if_valid), 32'd0);

        // Burst with IF idle.
        start_burst(0, 4);
        collect(20, 0);
        check("burst_count", 32'(got_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            check("burst_data", got_data[i], exp_b[i]);
            check("burst_idx",  32'(got_idx[i]), 32'(i));
            check("burst_cyc",  32'(got_cyc[i]), 32'(i + 1));
        end
        check("burst_done_cnt", 32'(done_cnt), 32'd1);
        check("burst_done_idx", 32'(done_idx), 32'd4);
        check("burst_busy_at_done", 32'(busy_at_done), 32'd0);
        step();

        // Starvation with IF requesting every cycle.
        if_req = 1'b1; if_addr = 9'd4;
        start_burst(1, 1);
        collect(30, 0);
        check("starve_count", 32'(got_data.size()), 32'd2);
        if (got_data.size() == 2) begin
            check("starve_cyc0",  32'(got_cyc[0]), 32'd5);
            check("starve_data0", got_data[0], 32'h8d100000);
            check("starve_cyc1",  32'(got_cyc[1]), 32'd10);
            check("starve_data1", got_data[1], 32'h00102021);
        end
        check("starve_stalls", 32'(n_stall), 32'd2);
        check("starve_done",   32'(done_cnt), 32'd1);
        if_req = 1'b0;
        step();

        // Address wrap.
        start_burst(510, 2);
        collect(20, 0);
        check("wrap_count", 32'(got_data.size()), 32'd3);
        check("wrap_addr_count", 32'(got_addr.size()), 32'd3);
        if (got_data.size() == 3 && got_addr.size() == 3) begin
            check("wrap_data0", got_data[0], rom[510]);
            check("wrap_data1", got_data[1], 32'h00000000);
            check("wrap_data2", got_data[2], 32'h00000000);
            check("wrap_idx2",  32'(got_idx[2]), 32'd2);
            check("wrap_addr0", 32'(got_addr[0]), 32'h1fe);
            check("wrap_addr1", 32'(got_addr[1]), 32'h1ff);
            check("wrap_addr2", 32'(got_addr[2]), 32'h000);
        end
        step();

        // Start pulsed mid-burst is ignored.
        start_burst(0, 4);
        collect(20, 2);
        check("ign_count", 32'(got_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_data.size(); i++) check("ign_data", got_data[i], exp_b[i]);
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        step(); step();
        check("ign_idle_after", 32'(dbg_busy), 32'd0);

        // Reset in the middle of a burst.
        start_burst(0, 9);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("rst_busy",  32'(dbg_busy),  32'd0);
        check("rst_valid", 32'(dbg_valid), 32'd0);
        check("rst_done",  32'(dbg_done),  32'd0);
        check("rst_data",  dbg_data,       32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (dbg_done) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        start_burst(2, 0);
        collect(10, 0);
        check("rst_new_count", 32'(got_data.size()), 32'd1);
        if (got_data.size() == 1) check("rst_new_data", got_data[0], 32'h00102021);
        check("rst_new_done", 32'(done_cnt), 32'd1);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
